// File: rtl/ex_unit_mc_pkg.sv
// rtl/ex_unit_mc_pkg.sv - shared types, encodings and helpers for the execute stage
package ex_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL
  } alu_e;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HOLD} state_e;

  typedef enum logic [1:0] {FWD_REG, FWD_EXMEM, FWD_MEMWB} fwd_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_DFLT  = 2'b11;

  // EX/MEM is checked first so the younger producer wins; x0 never forwards.
  function automatic fwd_e fwd_select(input logic [4:0] idx,
                                      input logic       exmem_regwrite,
                                      input logic [4:0] exmem_rd,
                                      input logic       memwb_regwrite,
                                      input logic [4:0] memwb_rd);
    fwd_e sel;
    sel = FWD_REG;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == idx))
      sel = FWD_EXMEM;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == idx))
      sel = FWD_MEMWB;
    return sel;
  endfunction

  function automatic alu_e decode(input logic [1:0] alu_op,
                                  input logic [2:0] funct3,
                                  input logic [6:0] funct7,
                                  input logic       mul_en);
    alu_e op;
    op = OP_ADD;
    case (alu_op)
      ALU_OP_SUB: op = OP_SUB;
      ALU_OP_RTYPE: begin
        if (funct7 == 7'b0000001) begin
          if (funct3 == 3'b000 && mul_en) op = OP_MUL;
          else                            op = OP_ADD;
        end else begin
          case (funct3)
            3'b000: op = funct7[5] ? OP_SUB : OP_ADD;
            3'b001: op = OP_SLL;
            3'b010: op = OP_SLT;
            3'b011: op = OP_SLTU;
            3'b100: op = OP_XOR;
            3'b101: op = funct7[5] ? OP_SRA : OP_SRL;
            3'b110: op = OP_OR;
            3'b111: op = OP_AND;
            default: op = OP_ADD;
          endcase
        end
      end
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ex_unit_mc_if.sv
// rtl/ex_unit_mc_if.sv - ID/EX, forwarding and EX/MEM handshake bundle
interface ex_unit_mc_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [1:0]      alu_op;
  logic            alu_src;
  logic [4:0]      exmem_rd;
  logic [4:0]      memwb_rd;
  logic            exmem_regwrite;
  logic            memwb_regwrite;
  logic [XLEN-1:0] exmem_fwd;
  logic [XLEN-1:0] memwb_fwd;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic [XLEN-1:0] out_target;
  logic            out_zero;

  modport master (
    output in_valid, pc, rs1_val, rs2_val, imm, rs1_idx, rs2_idx, funct3, funct7,
           alu_op, alu_src, exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
           exmem_fwd, memwb_fwd, out_ready,
    input  in_ready, out_valid, out_result, out_target, out_zero
  );

  modport slave (
    input  in_valid, pc, rs1_val, rs2_val, imm, rs1_idx, rs2_idx, funct3, funct7,
           alu_op, alu_src, exmem_rd, memwb_rd, exmem_regwrite, memwb_regwrite,
           exmem_fwd, memwb_fwd, out_ready,
    output in_ready, out_valid, out_result, out_target, out_zero
  );
endinterface

// File: rtl/ex_unit_mc_mul_iter.sv
// rtl/ex_unit_mc_mul_iter.sv - iterative shift-add multiplier, low XLEN bits of product
module ex_mul_iter #(parameter int XLEN = 64) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);
  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] acc_next;

  // product presents the accumulator including the current step, so the
  // final partial sum is usable on the same edge that retires the last bit.
  assign acc_next = acc + (mcand[0] ? mplier : '0);
  assign done     = busy && (cnt == CW'(XLEN - 1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (flush) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand >> 1;
      mplier <= mplier << 1;
      cnt    <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/ex_unit_mc.sv
// rtl/ex_unit_mc.sv - multi-cycle execute stage: forwarding, ALU, branch target, MUL
module ex_unit_mc
  import ex_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter bit MUL_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  ex_unit_mc_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  state_e          state, state_next;
  alu_e            op;
  fwd_e            sel_a, sel_b;
  logic [XLEN-1:0] opa, rs2_fwd, opb, alu_res, target, mul_product;
  logic [SHW-1:0]  shamt;
  logic            accept, load_alu, mul_start, mul_done;
  logic            out_valid_q, zero_q;
  logic [XLEN-1:0] result_q, target_q;

  assign sel_a = fwd_select(bus.rs1_idx, bus.exmem_regwrite, bus.exmem_rd,
                            bus.memwb_regwrite, bus.memwb_rd);
  assign sel_b = fwd_select(bus.rs2_idx, bus.exmem_regwrite, bus.exmem_rd,
                            bus.memwb_regwrite, bus.memwb_rd);

  always_comb begin
    case (sel_a)
      FWD_EXMEM: opa = bus.exmem_fwd;
      FWD_MEMWB: opa = bus.memwb_fwd;
      default:   opa = bus.rs1_val;
    endcase
    case (sel_b)
      FWD_EXMEM: rs2_fwd = bus.exmem_fwd;
      FWD_MEMWB: rs2_fwd = bus.memwb_fwd;
      default:   rs2_fwd = bus.rs2_val;
    endcase
  end

  assign opb    = bus.alu_src ? bus.imm : rs2_fwd;
  assign shamt  = opb[SHW-1:0];
  assign op     = decode(bus.alu_op, bus.funct3, bus.funct7, MUL_EN);
  assign target = bus.pc + (bus.imm << 1);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_SUB:  alu_res = opa - opb;
      OP_SLL:  alu_res = opa << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(opa) < $signed(opb))};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, (opa < opb)};
      OP_XOR:  alu_res = opa ^ opb;
      OP_SRL:  alu_res = opa >> shamt;
      OP_SRA:  alu_res = $signed(opa) >>> shamt;
      OP_OR:   alu_res = opa | opb;
      OP_AND:  alu_res = opa & opb;
      default: alu_res = opa + opb;
    endcase
  end

  assign bus.in_ready = rst_n && ((state == ST_IDLE) || (state == ST_HOLD && bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_alu   = 1'b0;
    mul_start  = 1'b0;
    if (flush) begin
      state_next = ST_IDLE;
    end else if (accept) begin
      if (op == OP_MUL) begin
        mul_start  = 1'b1;
        state_next = ST_MUL;
      end else begin
        load_alu   = 1'b1;
        state_next = ST_HOLD;
      end
    end else begin
      case (state)
        ST_MUL:  if (mul_done) state_next = ST_HOLD;
        ST_HOLD: if (bus.out_ready) state_next = ST_IDLE;
        default: state_next = state;
      endcase
    end
  end

  ex_mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .start   (mul_start),
    .a       (opa),
    .b       (opb),
    .done    (mul_done),
    .product (mul_product)
  );

  // A new load on the handshake edge overrides the valid clear below it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      target_q    <= '0;
      zero_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else begin
      if (state == ST_HOLD && bus.out_ready) out_valid_q <= 1'b0;
      if (load_alu || mul_start) target_q <= target;
      if (load_alu) begin
        result_q    <= alu_res;
        zero_q      <= (alu_res == '0);
        out_valid_q <= 1'b1;
      end
      if (state == ST_MUL && mul_done) begin
        result_q    <= mul_product;
        zero_q      <= (mul_product == '0);
        out_valid_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_target = target_q;
  assign bus.out_zero   = zero_q;
endmodule
